// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

   // Widest requester vector the index helper accepts.
   localparam int OH_MAXW = 32;
   localparam int OH_IDXW = $clog2(OH_MAXW);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Binary index of a one-hot vector; an all-zero vector yields 0.
   function automatic logic [OH_IDXW-1:0] oh_idx(input logic [OH_MAXW-1:0] v);
      logic [OH_IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < OH_MAXW; i++) begin
         if (v[i]) idx = idx | OH_IDXW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin winner selection: first request past ptr in the
// search direction, wrapping to the first request from the start edge.
module rr_arb_pick
   import rr_arb_pkg::*;
#(
   parameter int W           = 4,
   parameter bit TOWARDS_LSB = 1'b0
) (
   input  logic [W-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] win
);

   logic [W-1:0] past;
   logic [W-1:0] masked;
   logic [W-1:0] win_m;
   logic [W-1:0] win_a;
   logic         found_m;
   logic         found_a;

   // Mark the positions strictly beyond ptr in the search direction.
   always_comb begin
      logic seen;
      past = '0;
      seen = 1'b0;
      for (int k = 0; k < W; k++) begin
         int i;
         i = TOWARDS_LSB ? (W - 1 - k) : k;
         past[i] = seen;
         seen    = seen | ptr[i];
      end
   end

   assign masked = req & past;

   // First set bit in search order, both for the masked and the full request.
   always_comb begin
      win_m   = '0;
      win_a   = '0;
      found_m = 1'b0;
      found_a = 1'b0;
      for (int k = 0; k < W; k++) begin
         int i;
         i = TOWARDS_LSB ? (W - 1 - k) : k;
         if (!found_m && masked[i]) begin
            win_m[i] = 1'b1;
            found_m  = 1'b1;
         end
         if (!found_a && req[i]) begin
            win_a[i] = 1'b1;
            found_a  = 1'b1;
         end
      end
   end

   // Wrap to the start edge only when nothing lies past the pointer.
   always_comb begin
      win = found_m ? win_m : win_a;
   end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with registered one-hot grant.
// Optional macro RR_ARB_LOCK_EN: adds i_last; a grant is only released by
// i_ack together with i_last, so multi-beat transfers keep the bus.
//
// state | meaning
// IDLE  | no grant outstanding, o_gnt = 0
// GRANT | o_gnt holds the current winner, o_gnt_vld = 1
module rr_arb
   import rr_arb_pkg::*;
#(
   parameter int W           = 4,
   parameter bit TOWARDS_LSB = 1'b0
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic [W-1:0]         i_req,
   input  logic                 i_ack,
`ifdef RR_ARB_LOCK_EN
   input  logic                 i_last,
`endif
   output logic [W-1:0]         o_gnt,
   output logic [$clog2(W)-1:0] o_gnt_enc,
   output logic                 o_gnt_vld
);

   localparam int EW = $clog2(W);
   // Pointer starts on the edge opposite the search start so bit 0 (or W-1)
   // wins first after reset.
   localparam logic [W-1:0] PTR_RST = TOWARDS_LSB ? W'(1) : (W'(1) << (W - 1));

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] ptr;
   logic [W-1:0] ptr_nxt;
   logic [W-1:0] gnt_nxt;
   logic [W-1:0] ptr_pick;
   logic [W-1:0] win;
   logic         done;

`ifdef RR_ARB_LOCK_EN
   assign done = i_ack & i_last;
`else
   assign done = i_ack;
`endif

   // On completion the finishing grant becomes the pointer for the same-cycle
   // re-arbitration, which is what allows back-to-back grants.
   assign ptr_pick = (state == GRANT) ? o_gnt : ptr;

   rr_arb_pick #(
      .W           (W),
      .TOWARDS_LSB (TOWARDS_LSB)
   ) u_pick (
      .req (i_req),
      .ptr (ptr_pick),
      .win (win)
   );

   // State, pointer and grant registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         ptr   <= PTR_RST;
         o_gnt <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         o_gnt <= gnt_nxt;
      end
   end

   // Next-state, next-pointer and next-grant decisions.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = o_gnt;
      case (state)
         IDLE: begin
            if (|i_req) begin
               gnt_nxt   = win;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (done) begin
               ptr_nxt = o_gnt;
               if (|i_req) begin
                  gnt_nxt = win;
               end else begin
                  gnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign o_gnt_vld = (state == GRANT);
   assign o_gnt_enc = EW'(oh_idx(OH_MAXW'(o_gnt)));

endmodule

// File: tb/tb_rr_arb.sv
// Scoreboard bench for rr_arb (W=4, TOWARDS_LSB=0). The driver pushes the
// reference model's expected post-edge outputs; the monitor pops and compares.
module tb_rr_arb;

   localparam int W  = 4;
   localparam int EW = $clog2(W);

   typedef struct {
      logic [W-1:0]  gnt;
      logic [EW-1:0] enc;
      logic          vld;
      string         tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic [W-1:0]  i_req = '0;
   logic          i_ack = 1'b0;
   logic          i_last = 1'b0;
   logic [W-1:0]  o_gnt;
   logic [EW-1:0] o_gnt_enc;
   logic          o_gnt_vld;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   // Reference model: index of current grant (-1 none), index of last winner.
   int   m_cur;
   int   m_last;

   rr_arb #(.W(W), .TOWARDS_LSB(1'b0)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_req     (i_req),
      .i_ack     (i_ack),
`ifdef RR_ARB_LOCK_EN
      .i_last    (i_last),
`endif
      .o_gnt     (o_gnt),
      .o_gnt_enc (o_gnt_enc),
      .o_gnt_vld (o_gnt_vld)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int next_winner(input logic [W-1:0] req, input int last);
      for (int k = 1; k <= W; k++) begin
         int j;
         j = (last + k) % W;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   function automatic exp_t model_out(input string tag);
      exp_t e;
      e.gnt = (m_cur < 0) ? '0 : (W'(1) << m_cur);
      e.enc = (m_cur < 0) ? '0 : EW'(m_cur);
      e.vld = (m_cur >= 0);
      e.tag = tag;
      return e;
   endfunction

   task automatic model_reset();
      m_cur  = -1;
      m_last = W - 1;
   endtask

   task automatic model_step(input logic [W-1:0] req, input logic ack, input logic last);
      logic fin;
`ifdef RR_ARB_LOCK_EN
      fin = ack & last;
`else
      fin = ack;
`endif
      if (m_cur < 0) begin
         if (req != 0) m_cur = next_winner(req, m_last);
      end else if (fin) begin
         m_last = m_cur;
         m_cur  = (req != 0) ? next_winner(req, m_last) : -1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus: drive at negedge, push expected post-edge outputs.
   task automatic cyc(input logic [W-1:0] req, input logic ack, input logic last, input string tag);
      @(negedge clk);
      arst_n = 1'b1;
      i_req  = req;
      i_ack  = ack;
      i_last = last;
      model_step(req, ack, last);
      exp_q.push_back(model_out(tag));
   endtask

   // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset(input string tag);
      exp_t e;
      @(negedge clk);
      arst_n = 1'b0;
      i_req  = '0;
      i_ack  = 1'b0;
      i_last = 1'b0;
      #1;
      check({tag, "_async_gnt"}, 32'(o_gnt), 32'h0);
      check({tag, "_async_vld"}, 32'(o_gnt_vld), 32'h0);
      check({tag, "_async_enc"}, 32'(o_gnt_enc), 32'h0);
      model_reset();
      e = model_out(tag);
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry per active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "_gnt"}, 32'(o_gnt), 32'(e.gnt));
            check({e.tag, "_enc"}, 32'(o_gnt_enc), 32'(e.enc));
            check({e.tag, "_vld"}, 32'(o_gnt_vld), 32'(e.vld));
            check({e.tag, "_onehot"}, 32'($onehot0(o_gnt)), 32'h1);
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      do_reset("rst0");

      // Idle with no requests.
      for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b0, 1'b0, "idle");

      // Full request, ack every cycle: 0001,0010,0100,1000,0001.
      for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b1, 1'b1, "all");
      cyc(4'b0000, 1'b1, 1'b1, "all_drain");

      // Sparse request 0101.
      do_reset("rst1");
      for (int i = 0; i < 4; i++) cyc(4'b0101, 1'b1, 1'b1, "sparse");
      cyc(4'b0000, 1'b1, 1'b1, "sparse_drain");

      // Grant 0010 held with no ack while requests toggle.
      do_reset("rst2");
      cyc(4'b0010, 1'b0, 1'b0, "hold_get");
      for (int i = 0; i < 5; i++) cyc((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, "hold");

      // ack in IDLE is ignored.
      do_reset("rst3");
      for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, 1'b1, "idle_ack");

`ifdef RR_ARB_LOCK_EN
      do_reset("rst4");
      cyc(4'b0011, 1'b0, 1'b0, "lock_get");
      for (int i = 0; i < 3; i++) cyc(4'b0011, 1'b1, 1'b0, "lock_hold");
      cyc(4'b0011, 1'b1, 1'b1, "lock_rel");
      cyc(4'b0000, 1'b0, 1'b0, "lock_after");
`endif

      // Reset during grant 0100, then full request restarts at 0001.
      do_reset("rst5");
      cyc(4'b0100, 1'b0, 1'b0, "mid_get");
      do_reset("mid_rst");
      for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1, 1'b1, "post_rst");

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] r;
         r = W'($urandom_range(0, (1 << W) - 1));
         if ($urandom_range(0, 3) == 0) r = '0;
         cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      // Starvation check: requester 2 held constantly, others random, ack always.
      begin
         int since;
         bit served;
         since  = 0;
         served = 1'b1;
         for (int i = 0; i < 60; i++) begin
            logic [W-1:0] r;
            r = W'($urandom_range(0, (1 << W) - 1)) | 4'b0100;
            cyc(r, 1'b1, 1'b1, "starve");
            @(posedge clk);
            #2;
            if (o_gnt_vld) begin
               if (o_gnt == 4'b0100) since = 0;
               else since++;
               if (since >= W) served = 1'b0;
            end
         end
         check("starve_bound", 32'(served), 32'h1);
      end

      @(posedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb.md
RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001 SHALL have parameter W, 4, number of requesters (W >= 2).
REQ-002 SHALL have parameter TOWARDS_LSB, 'b0, rotation direction: 0 searches upward from the last winner, 1 searches downward.
REQ-003 SHALL have port clk input 1 clock; all state updates on the rising edge.
REQ-004 SHALL have port arst_n input 1 reset; asynchronous, active-low.
REQ-005 SHALL have port i_req input W, per-requester request.
REQ-006 SHALL have port i_ack input 1, consumer accepts the current grant.
REQ-007 SHALL have port i_last input 1, final beat of the locked transfer (present only under RR_ARB_LOCK_EN).
REQ-008 SHALL have port o_gnt output W, registered one-hot grant.
REQ-009 SHALL have port o_gnt_enc output $clog2(W), binary index of o_gnt.
REQ-010 SHALL have port o_gnt_vld output 1, grant valid.

Function
REQ-011 SHALL implement FSM states IDLE (no grant) and GRANT (o_gnt_vld=1).
REQ-012 SHALL hold a one-hot pointer register ptr that records the last completed winner.
REQ-013 Winner SHALL be computed as follows (TOWARDS_LSB=0):
- take the first set bit of i_req strictly above ptr, searching upward;
- if there is none, take the lowest set bit of i_req.
- TOWARDS_LSB=1 mirrors both searches.
REQ-014 In IDLE with i_req != 0, the FSM SHALL load o_gnt with the winner and enter GRANT at the next edge (1-cycle latency).
REQ-015 In GRANT without i_ack, o_gnt/o_gnt_enc SHALL hold stable, independent of i_req changes, including deassertion of the granted bit.
REQ-016 In GRANT with i_ack (and i_last when locking), the block SHALL:
- set ptr to o_gnt;
- recompute the winner from the current i_req using the new ptr;
- if a winner exists, load it and stay in GRANT, giving back-to-back grants at one per cycle;
- otherwise clear o_gnt and enter IDLE.
REQ-017 o_gnt SHALL be zero whenever o_gnt_vld=0; o_gnt SHALL never have more than one bit set.
REQ-018 o_gnt_enc SHALL be derived combinationally from o_gnt, and SHALL be 0 when o_gnt is 0.
REQ-019 i_ack in IDLE SHALL be ignored.
REQ-020 A requester holding i_req continuously SHALL be granted within W grants (starvation-free).

Reset
REQ-021 Asserting arst_n low SHALL immediately set:
- o_gnt=0, o_gnt_vld=0, o_gnt_enc=0;
- FSM=IDLE;
- ptr=bit W-1 (TOWARDS_LSB=0) or bit 0 (TOWARDS_LSB=1).
REQ-022 After reset, with all requests high, the first grant SHALL go to bit 0 (TOWARDS_LSB=0) or bit W-1 (TOWARDS_LSB=1).
REQ-023 Reset mid-GRANT SHALL abandon the grant without updating ptr beyond its reset value.

Configuration
REQ-024 Macro RR_ARB_LOCK_EN defined:
- i_last exists;
- i_ack with i_last=0 SHALL keep o_gnt unchanged and ptr unchanged;
- only i_ack with i_last=1 performs REQ-016.
REQ-025 Macro RR_ARB_LOCK_EN undefined: i_last SHALL be absent and every i_ack SHALL be treated as i_last=1.

Structure
REQ-026 Package rr_arb_pkg SHALL hold the state enum (IDLE, GRANT) and a function returning the binary index of a one-hot vector.
REQ-027 Winner selection SHALL be a sub-module rr_arb_pick with these properties:
- parameters W and TOWARDS_LSB;
- inputs req and ptr;
- output one-hot winner;
- purely combinational.
REQ-028 All FSM, ptr and output registers SHALL reside in rr_arb.

Verification (W=4, TOWARDS_LSB=0)
REQ-029 Reset, then i_req=0 for 10 cycles -> o_gnt_vld=0 and o_gnt=0000 throughout.
REQ-030 i_req=1111 held, i_ack=1 every cycle -> o_gnt sequence 0001,0010,0100,1000,0001, with the first grant one cycle after i_req.
REQ-031 i_req=0101, ack each grant -> grants 0001,0100,0001; o_gnt_enc 0,2,0.
REQ-032 Grant 0010 with i_ack=0 for 5 cycles while i_req toggles 1111/0000 -> o_gnt stays 0010 and o_gnt_vld stays 1.
REQ-033 RR_ARB_LOCK_EN, i_req=0011:
- three acks with i_last=0 -> o_gnt remains 0001;
- ack with i_last=1 -> next o_gnt=0010.
REQ-034 arst_n low during grant 0100 -> outputs zero in the same cycle; after release with i_req=1111 -> first grant 0001.
